// File: rtl/sniffer_pkg.sv
// sniffer_pkg: record framing words and FSM states shared by hit_record_writer.
// The LEN state is only reached when HITWR_WORDCOUNT_EN is defined.
package sniffer_pkg;

  localparam logic [31:0] START_WORD = 32'hF00BF00B;
  localparam logic [31:0] STOP_WORD  = 32'hDEADF00B;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LEN
  } hitwr_state_t;

endpackage

// File: rtl/hit_fifo.sv
// hit_fifo: synchronous FIFO with wrap-bit pointers.
// It exposes the head and the entry behind it so a popping reader can chain beats.
module hit_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic             more,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] head_nxt
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [AW:0]      cnt;
  logic [AW-1:0]    ridx_nxt;
  logic             do_push;
  logic             do_pop;

  assign cnt      = wptr_q - rptr_q;
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (wptr_q == rptr_q);
  assign more     = (cnt > (AW+1)'(1));
  assign ridx_nxt = rptr_q[AW-1:0] + AW'(1);
  assign head     = mem_q[rptr_q[AW-1:0]];
  assign head_nxt = mem_q[ridx_nxt];
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/hit_record_writer.sv
// hit_record_writer: frames sniffer words into START/payload/STOP records in an SDRAM ring.
// Define HITWR_WORDCOUNT_EN to append a LEN word carrying the payload count.
module hit_record_writer
  import sniffer_pkg::*;
#(
  parameter int                   ADDRWIDTH  = 26,
  parameter int                   DATAWIDTH  = 32,
  parameter int                   FIFO_DEPTH = 16,
  parameter logic [ADDRWIDTH-1:0] BASE_ADDR  = '0,
  parameter int                   RING_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_sop,
  input  logic                 in_eop,
  output logic                 in_ready,
  output logic [ADDRWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0] master_writedata,
  output logic                 master_write,
  input  logic                 master_waitrequest,
  output logic [ADDRWIDTH-1:0] wr_ptr,
  output logic [31:0]          record_cnt,
  output logic [15:0]          drop_cnt,
  output logic                 busy
);

  localparam int EW = DATAWIDTH + 2;
  localparam logic [ADDRWIDTH:0] RING_END =
    {1'b0, BASE_ADDR} + (ADDRWIDTH+1)'(RING_WORDS * 4);

  hitwr_state_t         state_q;
  logic                 mw_q;
  logic [ADDRWIDTH-1:0] maddr_q;
  logic [ADDRWIDTH-1:0] wr_ptr_q;
  logic [DATAWIDTH-1:0] mdata_q;
  logic [31:0]          rec_q;
  logic [15:0]          drop_q;
  logic                 cur_eop_q;
  logic                 wrote_q;
`ifdef HITWR_WORDCOUNT_EN
  logic [15:0]          pw_q;
`endif

  logic                 f_full;
  logic                 f_empty;
  logic                 f_more;
  logic [EW-1:0]        f_head;
  logic [EW-1:0]        f_head_nxt;
  logic                 f_push;
  logic                 f_pop;
  logic                 f_flush;

  logic                 beat_done;
  logic [ADDRWIDTH:0]   p4;
  logic [ADDRWIDTH-1:0] ptr_inc;
  logic [ADDRWIDTH-1:0] load_addr;
  logic                 cand_vld;
  logic [EW-1:0]        cand;
  logic                 wrote_eff;
  logic                 do_load;
  logic                 load_stop;

  assign beat_done = mw_q && !master_waitrequest;
  assign p4        = {1'b0, wr_ptr_q} + (ADDRWIDTH+1)'(4);
  assign ptr_inc   = (p4 == RING_END) ? BASE_ADDR : p4[ADDRWIDTH-1:0];
  assign load_addr = beat_done ? ptr_inc : wr_ptr_q;

  assign in_ready = !f_full;
  assign f_push   = in_valid && !f_full;
  assign f_flush  = clear && (state_q == IDLE);
  assign f_pop    = ((state_q == IDLE) && !clear && !f_empty && !f_head[EW-1])
                 || ((state_q == DATA) && beat_done);

  hit_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .flush   (f_flush),
    .push    (f_push),
    .pop     (f_pop),
    .wdata   ({in_sop, in_eop, in_data}),
    .full    (f_full),
    .empty   (f_empty),
    .more    (f_more),
    .head    (f_head),
    .head_nxt(f_head_nxt)
  );

  // A completing DATA beat pops the head, so the next word is the one behind it.
  always_comb begin
    cand_vld  = !f_empty;
    cand      = f_head;
    wrote_eff = 1'b0;
    do_load   = 1'b0;
    if ((state_q == DATA) && beat_done) begin
      cand_vld = f_more;
      cand     = f_head_nxt;
    end
    if (state_q == DATA) begin
      wrote_eff = wrote_q || beat_done;
      do_load   = !mw_q || (beat_done && !cur_eop_q);
    end
    if (state_q == START) do_load = beat_done;
    load_stop = cand_vld && cand[EW-1] && wrote_eff;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      mw_q      <= 1'b0;
      maddr_q   <= BASE_ADDR;
      mdata_q   <= '0;
      wr_ptr_q  <= BASE_ADDR;
      rec_q     <= '0;
      drop_q    <= '0;
      cur_eop_q <= 1'b0;
      wrote_q   <= 1'b0;
`ifdef HITWR_WORDCOUNT_EN
      pw_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clear) begin
            wr_ptr_q <= BASE_ADDR;
            rec_q    <= '0;
            drop_q   <= '0;
          end else if (!f_empty) begin
            if (f_head[EW-1]) begin
              if (enable) state_q <= START;
            end else if (drop_q != 16'hFFFF) begin
              drop_q <= drop_q + 16'd1;
            end
          end
        end
        START: begin
          if (!mw_q) begin
            mw_q    <= 1'b1;
            maddr_q <= wr_ptr_q;
            mdata_q <= DATAWIDTH'(START_WORD);
          end else if (beat_done) begin
            wr_ptr_q <= ptr_inc;
            state_q  <= DATA;
            wrote_q  <= 1'b0;
`ifdef HITWR_WORDCOUNT_EN
            pw_q     <= '0;
`endif
          end
        end
        DATA: begin
          if (beat_done) begin
            wr_ptr_q <= ptr_inc;
            wrote_q  <= 1'b1;
`ifdef HITWR_WORDCOUNT_EN
            pw_q     <= pw_q + 16'd1;
`endif
            if (cur_eop_q) begin
              state_q <= STOP;
              maddr_q <= ptr_inc;
              mdata_q <= DATAWIDTH'(STOP_WORD);
            end
          end
        end
        STOP: begin
          if (beat_done) begin
            wr_ptr_q <= ptr_inc;
`ifdef HITWR_WORDCOUNT_EN
            state_q  <= LEN;
            maddr_q  <= ptr_inc;
            mdata_q  <= DATAWIDTH'({16'h0, pw_q});
`else
            rec_q    <= rec_q + 32'd1;
            state_q  <= IDLE;
            mw_q     <= 1'b0;
`endif
          end
        end
        LEN: begin
          if (beat_done) begin
            wr_ptr_q <= ptr_inc;
            rec_q    <= rec_q + 32'd1;
            state_q  <= IDLE;
            mw_q     <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (do_load) begin
        maddr_q <= load_addr;
        if (!cand_vld) begin
          mw_q <= 1'b0;
        end else if (load_stop) begin
          state_q <= STOP;
          mw_q    <= 1'b1;
          mdata_q <= DATAWIDTH'(STOP_WORD);
        end else begin
          mw_q      <= 1'b1;
          mdata_q   <= cand[DATAWIDTH-1:0];
          cur_eop_q <= cand[EW-2];
        end
      end
    end
  end

  assign master_address   = maddr_q;
  assign master_writedata = mdata_q;
  assign master_write     = mw_q;
  assign wr_ptr           = wr_ptr_q;
  assign record_cnt       = rec_q;
  assign drop_cnt         = drop_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_hit_record_writer.sv
// tb_hit_record_writer: directed and random records checked against a stream-level model.
// The model appends a LEN word when HITWR_WORDCOUNT_EN is defined.
module tb_hit_record_writer;
  import sniffer_pkg::*;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic          master_waitrequest = 1'b0;
  logic          in_ready;
  logic [AW-1:0] master_address;
  logic [DW-1:0] master_writedata;
  logic          master_write;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   record_cnt;
  logic [15:0]   drop_cnt;
  logic          busy;

  hit_record_writer #(
    .ADDRWIDTH (AW),
    .DATAWIDTH (DW),
    .FIFO_DEPTH(16),
    .BASE_ADDR ('0),
    .RING_WORDS(RW)
  ) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .enable            (enable),
    .clear             (clear),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_sop            (in_sop),
    .in_eop            (in_eop),
    .in_ready          (in_ready),
    .master_address    (master_address),
    .master_writedata  (master_writedata),
    .master_write      (master_write),
    .master_waitrequest(master_waitrequest),
    .wr_ptr            (wr_ptr),
    .record_cnt        (record_cnt),
    .drop_cnt          (drop_cnt),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [31:0]   exp_q [$];
  logic [AW-1:0] exp_ptr = '0;
  int            rec_exp = 0;
  int            drop_exp = 0;
  int            beats = 0;
  int            b0;
  bit            acc = 1'b0;
  bit            rand_wait = 1'b0;
  bit            in_rec = 1'b0;
  int            npay = 0;
  bit            held = 1'b0;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_data;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] adv(input logic [AW-1:0] p);
    return AW'((int'(p) + 4) % (RW * 4));
  endfunction

  task automatic close_rec();
    exp_q.push_back(STOP_WORD);
`ifdef HITWR_WORDCOUNT_EN
    exp_q.push_back({16'h0, 16'(npay)});
`endif
    rec_exp++;
    in_rec = 1'b0;
  endtask

  // Stream model: records are framed purely from the order of accepted words.
  task automatic model_feed(input logic [31:0] d, input bit s, input bit e);
    if (in_rec && s && npay > 0) close_rec();
    if (!in_rec) begin
      if (!s) begin
        drop_exp++;
        return;
      end
      exp_q.push_back(START_WORD);
      in_rec = 1'b1;
      npay = 0;
    end
    exp_q.push_back(d);
    npay++;
    if (e) close_rec();
  endtask

  task automatic monitor();
    logic [31:0] want;
    if (held) begin
      chk("hold_addr", 64'(master_address), 64'(h_addr));
      chk("hold_data", 64'(master_writedata), 64'(h_data));
      chk("hold_write", 64'(master_write), 64'd1);
    end
    if (master_write && !master_waitrequest) begin
      n_chk++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_beat observed=%0h expected=none",
               master_writedata);
      end
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        chk("beat_data", 64'(master_writedata), 64'(want));
        chk("beat_addr", 64'(master_address), 64'(exp_ptr));
      end
      exp_ptr = adv(exp_ptr);
      beats++;
    end
    held   = master_write && master_waitrequest;
    h_addr = master_address;
    h_data = master_writedata;
  endtask

  task automatic tick();
    @(negedge clk);
    acc = in_valid && in_ready;
    monitor();
    @(posedge clk);
    #1;
    if (rand_wait) master_waitrequest = ($urandom_range(0, 3) == 0);
  endtask

  task automatic push_word(input logic [31:0] d, input bit s, input bit e);
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (acc) break;
    end
    chk("push_accept", 64'(acc), 64'd1);
    if (acc) model_feed(d, s, e);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_idle", 64'(busy), 64'd0);
    chk("wr_ptr", 64'(wr_ptr), 64'(exp_ptr));
    chk("record_cnt", 64'(record_cnt), 64'(rec_exp));
    chk("drop_cnt", 64'(drop_cnt), 64'(drop_exp));
  endtask

  initial begin
    #3;
    chk("rst_write", 64'(master_write), 64'd0);
    chk("rst_wdata", 64'(master_writedata), 64'd0);
    chk("rst_addr", 64'(master_address), 64'd0);
    chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
    chk("rst_rec", 64'(record_cnt), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    n_rst  = 1'b1;
    enable = 1'b1;

    // 3-word record, with the two-cycle start latency probed between pushes
    push_word(32'hA1, 1'b1, 1'b0);
    chk("lat_idle", 64'(busy), 64'd0);
    push_word(32'hA2, 1'b0, 1'b0);
    chk("lat_start_busy", 64'(busy), 64'd1);
    chk("lat_start_write", 64'(master_write), 64'd0);
    push_word(32'hA3, 1'b0, 1'b1);
    chk("lat_beat_write", 64'(master_write), 64'd1);
    chk("lat_beat_data", 64'(master_writedata), 64'(START_WORD));
    drain();
`ifdef HITWR_WORDCOUNT_EN
    chk("rec1_ptr", 64'(wr_ptr), 64'h18);
`else
    chk("rec1_ptr", 64'(wr_ptr), 64'h14);
`endif

    // second record stalls 5 cycles on its first payload beat, wrapping the ring
    b0 = beats;
    push_word(32'hB1, 1'b1, 1'b0);
    push_word(32'hB2, 1'b0, 1'b0);
    push_word(32'hB3, 1'b0, 1'b1);
    for (int i = 0; i < 50 && beats < b0 + 1; i++) tick();
    chk("start_beat_seen", 64'(beats - b0), 64'd1);
    master_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_addr", 64'(master_address), 64'(exp_ptr));
      chk("stall_data", 64'(master_writedata), 64'hB1);
    end
    master_waitrequest = 1'b0;
    drain();
`ifdef HITWR_WORDCOUNT_EN
    chk("rec2_ptr", 64'(wr_ptr), 64'h10);
`else
    chk("rec2_ptr", 64'(wr_ptr), 64'h8);
`endif

    // 20-word record against a stalled bus fills the FIFO at 16 entries
    master_waitrequest = 1'b1;
    for (int i = 0; i < 16; i++) push_word(32'hC00 + i, i == 0, 1'b0);
    chk("full_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data  = 32'hC10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_block", 64'(acc), 64'd0);
    end
    master_waitrequest = 1'b0;
    for (int i = 16; i < 20; i++) push_word(32'hC00 + i, 1'b0, i == 19);
    drain();

    // drops outside a record, then truncation by a fresh sop
    push_word(32'hD1, 1'b0, 1'b0);
    push_word(32'hD2, 1'b0, 1'b0);
    push_word(32'hE1, 1'b1, 1'b0);
    push_word(32'hE2, 1'b1, 1'b1);
    drain();
    chk("drop_two", 64'(drop_cnt), 64'd2);

    // enable=0 holds the record in the FIFO
    enable = 1'b0;
    b0 = beats;
    push_word(32'hF1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("en_busy", 64'(busy), 64'd0);
    chk("en_beats", 64'(beats - b0), 64'd0);
    enable = 1'b1;
    drain();

    // clear is ignored mid-record and honoured in IDLE
    push_word(32'h11, 1'b1, 1'b0);
    push_word(32'h12, 1'b0, 1'b0);
    chk("clr_busy", 64'(busy), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    push_word(32'h13, 1'b0, 1'b1);
    drain();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ptr", 64'(wr_ptr), 64'd0);
    chk("clr_rec", 64'(record_cnt), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);
    exp_ptr  = '0;
    rec_exp  = 0;
    drop_exp = 0;

    // random records, gaps, stalls and occasional missing eop
    rand_wait = 1'b1;
    for (int r = 0; r < 12; r++) begin
      int len;
      bit noeop;
      len   = $urandom_range(1, 6);
      noeop = (r != 11) && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) push_word($urandom, 1'b0, 1'b0);
      for (int w = 0; w < len; w++) begin
        push_word($urandom, w == 0, (w == len - 1) && !noeop);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    drain();
    rand_wait = 1'b0;
    master_waitrequest = 1'b0;

    // reset mid-record abandons it without a STOP word
    push_word(32'h21, 1'b1, 1'b0);
    push_word(32'h22, 1'b0, 1'b0);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_write", 64'(master_write), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ptr", 64'(wr_ptr), 64'd0);
    chk("mid_rst_rec", 64'(record_cnt), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    exp_ptr  = '0;
    rec_exp  = 0;
    drop_exp = 0;
    in_rec   = 1'b0;
    held     = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    push_word(32'h31, 1'b1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
